// File: rtl/arith_seq_unit.sv
// rtl/arith_seq_unit.sv - sequential add/sub/mul/div unit with valid/ready handshake
// The restoring divider is built only when ARITH_SEQ_DIV_EN is defined; otherwise sel=11 flags err.
module arith_seq_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_a;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  logic               r_carry;
  logic               r_err;

  logic               w_accept;
  logic               w_last;
  logic               w_calc_err;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_step_next;

  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_cnt == CNT_LAST);

  // Bit WIDTH of the extended difference is the borrow, i.e. a < b.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  // Accumulator holds {partial_high, multiplier}; the low half drains as product bits shift in.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

`ifdef ARITH_SEQ_DIV_EN
  logic [WIDTH-1:0]   r_b;
  logic [1:0]         r_sel;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH-1:0]   w_div_trial;
  logic               w_div_ok;
  logic [2*WIDTH-1:0] w_div_next;

  // Accumulator holds {remainder, dividend/quotient}; with b=0 every trial succeeds,
  // which naturally leaves quotient all ones and remainder equal to a.
  assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_ok    = (w_div_shift >= {1'b0, r_b});
  assign w_div_trial = w_div_shift[WIDTH-1:0] - r_b;
  assign w_div_next  = w_div_ok ? {w_div_trial, r_acc[WIDTH-2:0], 1'b1}
                                : {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
  assign w_calc_err  = (r_sel == OP_DIV) && (r_b == '0);

  always_comb begin
    w_step_next = w_mul_next;
    if (r_sel == OP_DIV) begin
      w_step_next = w_div_next;
    end
  end
`else
  assign w_calc_err = 1'b0;

  always_comb begin
    w_step_next = w_mul_next;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_carry     <= 1'b0;
      r_err       <= 1'b0;
`ifdef ARITH_SEQ_DIV_EN
      r_b         <= '0;
      r_sel       <= OP_ADD;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a   <= a;
            r_cnt <= '0;
`ifdef ARITH_SEQ_DIV_EN
            r_b   <= b;
            r_sel <= sel;
`endif
            case (sel)
              OP_ADD: begin
                r_result    <= w_sum[WIDTH-1:0];
                r_result_hi <= '0;
                r_carry     <= w_sum[WIDTH];
                r_err       <= 1'b0;
                r_state     <= S_DONE;
              end
              OP_SUB: begin
                r_result    <= w_diff[WIDTH-1:0];
                r_result_hi <= '0;
                r_carry     <= w_diff[WIDTH];
                r_err       <= 1'b0;
                r_state     <= S_DONE;
              end
              OP_MUL: begin
                r_acc   <= {{WIDTH{1'b0}}, b};
                r_state <= S_CALC;
              end
              OP_DIV: begin
`ifdef ARITH_SEQ_DIV_EN
                r_acc   <= {{WIDTH{1'b0}}, a};
                r_state <= S_CALC;
`else
                r_result    <= '0;
                r_result_hi <= '0;
                r_carry     <= 1'b0;
                r_err       <= 1'b1;
                r_state     <= S_DONE;
`endif
              end
            endcase
          end
        end
        S_CALC: begin
          r_acc <= w_step_next;
          r_cnt <= r_cnt + CNT_ONE;
          if (w_last) begin
            r_result    <= w_step_next[WIDTH-1:0];
            r_result_hi <= w_step_next[2*WIDTH-1:WIDTH];
            r_carry     <= 1'b0;
            r_err       <= w_calc_err;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign carry     = r_carry;
  assign err       = r_err;
  assign zero      = (r_result == '0) && (r_result_hi == '0);

endmodule

// File: tb/tb_arith_seq_unit.sv
// tb/tb_arith_seq_unit.sv - scoreboard bench for arith_seq_unit against an arithmetic reference model
module tb_arith_seq_unit;
  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   sel = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         carry;
  logic         zero;
  logic         err;

  typedef struct {
    int res;
    int hi;
    int carry;
    int zero;
    int err;
    int lat;
    int acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  bit   prev_valid = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  arith_seq_unit #(.WIDTH(W), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .carry     (carry),
    .zero      (zero),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic exp_t model(int av, int bv, int s);
    exp_t e;
    e.res = 0; e.hi = 0; e.carry = 0; e.err = 0; e.lat = 1; e.acc_cyc = 0;
    case (s)
      0: begin
        e.res   = (av + bv) & MASK;
        e.carry = ((av + bv) > MASK) ? 1 : 0;
      end
      1: begin
        e.res   = (av - bv) & MASK;
        e.carry = (av < bv) ? 1 : 0;
      end
      2: begin
        e.res = (av * bv) & MASK;
        e.hi  = (av * bv) / (MASK + 1);
        e.lat = W + 1;
      end
      default: begin
`ifdef ARITH_SEQ_DIV_EN
        e.lat = W + 1;
        if (bv == 0) begin
          e.res = MASK; e.hi = av; e.err = 1;
        end else begin
          e.res = av / bv; e.hi = av % bv;
        end
`else
        e.err = 1;
`endif
      end
    endcase
    e.zero = (e.res == 0 && e.hi == 0) ? 1 : 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      have_cur   = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          have_cur = 1'b0;
          $display("FAIL unexpected_out_valid: got 1 expected 0 (t=%0t)", $time);
        end else begin
          cur = sb.pop_front();
          have_cur = 1'b1;
          check("latency", cyc - cur.acc_cyc + 1, cur.lat);
        end
      end
      if (out_valid && have_cur) begin
        check("result", int'(result), cur.res);
        check("result_hi", int'(result_hi), cur.hi);
        check("carry", int'(carry), cur.carry);
        check("zero", int'(zero), cur.zero);
        check("err", int'(err), cur.err);
        check("in_ready_in_done", int'(in_ready), 0);
      end
      prev_valid = out_valid;
    end
  end

  task automatic do_op(input int av, input int bv, input int s, input int hold);
    exp_t e;
    int n;
    int held;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1 (t=%0t)", $time);
      return;
    end
    a = W'(av); b = W'(bv); sel = 2'(s); in_valid = 1'b1;
    e = model(av, bv, s);
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    held = 0;
    n = 0;
    while (n < 60) begin
      if (out_valid) begin
        if (held >= hold) begin
          // in_valid stays high across the consuming edge and must be ignored there
          out_ready = 1'b1;
          in_valid  = 1'b1;
          a = W'($urandom); b = W'($urandom); sel = 2'($urandom);
          @(negedge clk);
          out_ready = 1'b0;
          in_valid  = 1'b0;
          check("in_ready_after_consume", int'(in_ready), 1);
          check("out_valid_after_consume", int'(out_valid), 0);
          return;
        end
        held++;
      end
      in_valid  = 1'($urandom);
      a = W'($urandom); b = W'($urandom); sel = 2'($urandom);
      out_ready = 1'b0;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL out_valid_timeout: got 0 expected 1 (t=%0t)", $time);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int bv;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_result", int'(result), 0);
    check("rst_result_hi", int'(result_hi), 0);
    check("rst_carry", int'(carry), 0);
    check("rst_err", int'(err), 0);
    check("rst_zero", int'(zero), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);

    do_op(200, 100, 0, 0);
    do_op(5, 7, 1, 0);
    do_op(9, 9, 1, 0);
    do_op(200, 3, 2, 0);
    do_op(100, 7, 3, 0);
    do_op(100, 0, 3, 0);
    do_op(37, 11, 2, 5);
    do_op(250, 9, 0, 5);

    // abort a multiply in its fourth CALC cycle
    do_op(200, 100, 0, 0);
    a = W'(200); b = W'(3); sel = 2'd2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_result", int'(result), 0);
    check("abort_result_hi", int'(result_hi), 0);
    check("abort_carry", int'(carry), 0);
    check("abort_err", int'(err), 0);
    check("abort_out_valid", int'(out_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_in_ready", int'(in_ready), 1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("abort_no_out_valid", seen, 0);
    do_op(17, 42, 0, 0);

    for (int i = 0; i < 150; i++) begin
      bv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, MASK));
      do_op(int'($urandom_range(0, MASK)), bv, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arith_seq_unit.md
ARITH_SEQ_UNIT -- requirements
Module: arith_seq_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: operand width in bits, minimum 2.
REQ-002 SHALL provide parameter CNT_W, default 4: iteration counter width, at least clog2(WIDTH+1).
REQ-003 SHALL use one clock and an asynchronous active-low reset; ports are listed below.
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand/op request.
- in_ready  output  1  unit can accept a request.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sel  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  sum, difference, product low half, or quotient.
- result_hi  output  WIDTH  product high half or remainder; 0 for add and sub.
- carry  output  1  add carry-out, or sub borrow (a<b); 0 for mul and div.
- zero  output  1  high when result and result_hi are both 0.
- err  output  1  divide-by-zero, or unsupported op.

Function
REQ-004 SHALL implement FSM states IDLE, CALC and DONE; in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-005 SHALL accept a request on the edge where in_valid&in_ready=1, registering a, b and sel; inputs are ignored at all other times.
REQ-006 SHALL, for add or sub, go IDLE->DONE on the accepting edge, so out_valid is high 1 cycle after acceptance.
REQ-007 SHALL compute add and sub modulo 2^WIDTH, with carry = bit WIDTH of the unsigned result.
REQ-008 SHALL compute mul as an unsigned shift-add, one bit per cycle over WIDTH CALC cycles, giving the 2*WIDTH-bit product {result_hi,result}.
REQ-009 SHALL compute div as an unsigned restoring division, one bit per cycle over WIDTH CALC cycles: quotient to result, remainder to result_hi.
REQ-010 SHALL make out_valid rise exactly WIDTH+1 cycles after acceptance for mul and div.
REQ-011 SHALL, for div with b=0, still take WIDTH+1 cycles and produce result all ones, result_hi=a and err=1.
REQ-012 SHALL hold result, result_hi, carry, zero and err stable in DONE until out_valid&out_ready=1; that edge returns the FSM to IDLE.
REQ-013 SHALL not accept a new request in the cycle the result is consumed; the next acceptance is possible at the following edge.
REQ-014 SHALL derive zero combinationally from the registered result and result_hi.
REQ-015 SHALL hold out_valid=0 and the previous output values while the FSM is in IDLE and CALC.

Reset
REQ-016 SHALL, on rst_n=0 and independent of clk, force the FSM to IDLE and clear result, result_hi, carry, err, out_valid and the counter.
REQ-017 SHALL abort an operation in progress when reset is asserted mid-CALC; no result is delivered, and in_ready=1 on the first edge after reset is released.

Configuration
REQ-018 SHALL compile the divider only when macro ARITH_SEQ_DIV_EN is defined.
REQ-019 SHALL, with ARITH_SEQ_DIV_EN defined, behave for sel=11 as REQ-009 to REQ-011.
REQ-020 SHALL, with ARITH_SEQ_DIV_EN undefined, complete sel=11 in 1 cycle with result=0, result_hi=0 and err=1, and contain no divider logic.

Verification (WIDTH=8, ARITH_SEQ_DIV_EN defined unless noted)
REQ-021 SHALL test add: a=200, b=100, sel=00 -> after 1 cycle result=44, result_hi=0, carry=1, zero=0.
REQ-022 SHALL test sub: a=5, b=7, sel=01 -> result=254, carry=1; then a=9, b=9 -> result=0, zero=1, carry=0.
REQ-023 SHALL test mul: a=200, b=3, sel=10 -> out_valid exactly 9 cycles after acceptance, result=0x58, result_hi=0x02.
REQ-024 SHALL test div: a=100, b=7 -> result=14, result_hi=2, err=0; a=100, b=0 -> result=255, result_hi=100, err=1; with the macro undefined, a=100, b=7 -> 1 cycle, result=0, err=1.
REQ-025 SHALL test backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, and in_valid requests ignored; out_ready=1 -> IDLE on the next edge.
REQ-026 SHALL test reset: assert rst_n=0 at CALC cycle 4 of a mul -> outputs cleared immediately, no out_valid, and a new add is accepted after release.
